// File: rtl/mem_bus_bridge_pkg.sv
// Shared encodings for the CPU-to-memory-bus bridge: access sizes, FSM states,
// the default abandon timeout and the alignment rule.
`timescale 1ns/1ps
package mem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  // Halfwords must sit on even bytes, words on multiples of four.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return ~addr_lo[0];
      SZ_WORD: return addr_lo == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_bridge_lane_steer.sv
// Byte-lane steering: write strobes and replicated store data going out,
// shifted and sign/zero-extended load data coming back.
`timescale 1ns/1ps
module mem_bus_bridge_lane_steer
  import mem_bus_bridge_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    shifted    = rdata_raw >> {addr_lo, 3'b000};
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = shifted;
    case (size)
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridges single CPU load/store requests onto a req/ack memory bus, stalling
// the pipeline until the bus answers or the transfer times out.
`timescale 1ns/1ps
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_type,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        err_clr,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, result_q;
  logic [1:0]  size_q;
  logic        unsigned_q, we_q;
  logic [7:0]  cnt_q;
  logic        err_misalign_q, err_timeout_q;

  logic [3:0]  be_lane;
  logic [31:0] wdata_lane, rdata_ext;

  logic req_any, req_valid, accept, in_busy, expire;

  assign req_any   = cpu_rd_en | cpu_wr_en;
  assign req_valid = (cpu_rd_en ^ cpu_wr_en) && (cpu_type[1:0] != SZ_ILLEGAL)
                     && is_aligned(cpu_type[1:0], cpu_addr[1:0]);
  assign accept    = (state_q == IDLE) && req_valid;
  assign in_busy   = (state_q == BUSY);
  assign expire    = in_busy && !bus_ack && (cnt_q == LAST_CNT);

  mem_bus_bridge_lane_steer u_lane_steer (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .unsigned_ld (unsigned_q),
    .wdata       (wdata_q),
    .rdata_raw   (bus_rdata),
    .be          (be_lane),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext)
  );

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = BUSY;
      BUSY:    if (bus_ack || cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus side is driven only while BUSY, so an async reset drops it at once.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = '0;
    bus_wdata = '0;
    case (state_q)
      IDLE: cpu_stall = req_valid;
      BUSY: begin
        cpu_stall = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = {addr_q[31:2], 2'b00};
        bus_be    = be_lane;
        bus_wdata = wdata_lane;
      end
      DONE:    cpu_rdata = result_q;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      if (accept) begin
        addr_q     <= cpu_addr;
        wdata_q    <= cpu_wdata;
        size_q     <= cpu_type[1:0];
        unsigned_q <= cpu_type[2];
        we_q       <= cpu_wr_en;
        cnt_q      <= '0;
      end else if (in_busy && !bus_ack) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (in_busy && bus_ack)  result_q <= we_q ? 32'd0 : rdata_ext;
      else if (expire)         result_q <= '0;
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      if ((state_q == IDLE) && req_any && !req_valid) err_misalign_q <= 1'b1;
      else if (err_clr)                               err_misalign_q <= 1'b0;
      if (expire)       err_timeout_q <= 1'b1;
      else if (err_clr) err_timeout_q <= 1'b0;
    end
  end

  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;

endmodule
